in_pp_ram: RTL and testbench

//  Multi-bank (ping-pong) input buffer for the matrix engine: the loader streams tiles in, the compute core reads them.

---
 rtl/in_pp_ram_pkg.sv | 27 ++
 rtl/in_pp_bank.sv | 33 +++
 rtl/in_pp_ram.sv | 151 +++++++++++++++
 tb/tb_in_pp_ram.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/in_pp_ram_pkg.sv
// Shared definitions for the ping-pong input buffer: bank states, sizing helper, defaults.
package in_pp_ram_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_READING = 2'd3
  } bank_st_e;

  localparam int unsigned DEF_DWIDTH = 160;
  localparam int unsigned DEF_WORDS  = 64;
  localparam int unsigned DEF_NBANK  = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/in_pp_bank.sv
// One buffer bank: simple dual-port RAM, synchronous write, registered read that holds when idle.
module in_pp_bank
  import in_pp_ram_pkg::*;
#(
  parameter  int unsigned DWIDTH = DEF_DWIDTH,
  parameter  int unsigned WORDS  = DEF_WORDS,
  localparam int unsigned AWIDTH = clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem [WORDS];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/in_pp_ram.sv
// Multi-bank ping-pong input buffer: sequential fill by the loader, random-access read by the core.
// Optional IN_PP_RAM_OREG_EN adds an output register (latency 2) and an rvalid output.
module in_pp_ram
  import in_pp_ram_pkg::*;
#(
  parameter  int unsigned DWIDTH = DEF_DWIDTH,
  parameter  int unsigned WORDS  = DEF_WORDS,
  parameter  int unsigned NBANK  = DEF_NBANK,
  localparam int unsigned AWIDTH = clog2(WORDS),
  localparam int unsigned BWIDTH = clog2(NBANK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic              wlast,
  input  logic [DWIDTH-1:0] wdat,
  output logic              w_ready,
  output logic              w_ovf,
  output logic              r_avail,
  input  logic              rd_acq,
  input  logic              ren,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdat,
  output logic [AWIDTH:0]   rd_cnt,
`ifdef IN_PP_RAM_OREG_EN
  output logic              rvalid,
`endif
  input  logic              rd_rel
);

  bank_st_e          state_q [NBANK];
  bank_st_e          state_d [NBANK];
  logic [AWIDTH:0]   cnt_q   [NBANK];
  logic [AWIDTH:0]   cnt_d   [NBANK];
  logic [BWIDTH-1:0] wb_q, wb_d, rb_q, rb_d, rsel_q;
  logic [AWIDTH-1:0] wcnt_q, wcnt_d;
  logic              w_ready_q, w_ready_d, r_avail_q, r_avail_d, ovf_q, ovf_d;
  logic              wr_acc, w_close, rd_en;
  logic [DWIDTH-1:0] bank_rdata [NBANK];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q | (wen & ~w_ready_q);
    wr_acc  = wen & w_ready_q;
    w_close = wr_acc & (wlast | (wcnt_q == AWIDTH'(WORDS - 1)));
    rd_en   = ren & (state_q[rb_q] == ST_READING);

    if (wr_acc) begin
      if (w_close) begin
        state_d[wb_q] = ST_FULL;
        cnt_d[wb_q]   = {1'b0, wcnt_q} + (AWIDTH + 1)'(1);
        wb_d          = wb_q + BWIDTH'(1);
        wcnt_d        = '0;
      end else begin
        state_d[wb_q] = ST_FILLING;
        wcnt_d        = wcnt_q + AWIDTH'(1);
      end
    end

    // Write bank is EMPTY/FILLING while read actions need FULL/READING, so a
    // single rb decision never collides with the write-side update above.
    if (rd_rel && state_q[rb_q] == ST_READING) begin
      state_d[rb_q] = ST_EMPTY;
      rb_d          = rb_q + BWIDTH'(1);
    end else if (rd_acq && state_q[rb_q] == ST_FULL) begin
      state_d[rb_q] = ST_READING;
    end

    w_ready_d = (state_d[wb_d] == ST_EMPTY) || (state_d[wb_d] == ST_FILLING);
    r_avail_d = (state_d[rb_d] == ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NBANK; b++) begin
        state_q[b] <= ST_EMPTY;
        cnt_q[b]   <= '0;
      end
      wb_q      <= '0;
      rb_q      <= '0;
      rsel_q    <= '0;
      wcnt_q    <= '0;
      w_ready_q <= 1'b1;
      r_avail_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      wcnt_q    <= wcnt_d;
      w_ready_q <= w_ready_d;
      r_avail_q <= r_avail_d;
      ovf_q     <= ovf_d;
      if (rd_en) rsel_q <= rb_q;
    end
  end

  always_comb begin
    rd_cnt = '0;
    if (state_q[rb_q] == ST_FULL || state_q[rb_q] == ST_READING) rd_cnt = cnt_q[rb_q];
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    in_pp_bank #(
      .DWIDTH (DWIDTH),
      .WORDS  (WORDS)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_acc && (wb_q == BWIDTH'(b))),
      .waddr_i (wcnt_q),
      .wdata_i (wdat),
      .re_i    (rd_en && (rb_q == BWIDTH'(b))),
      .raddr_i (raddr),
      .rdata_o (bank_rdata[b])
    );
  end

  assign w_ready = w_ready_q;
  assign r_avail = r_avail_q;
  assign w_ovf   = ovf_q;

`ifdef IN_PP_RAM_OREG_EN
  logic              rvld1_q, rvalid_q;
  logic [DWIDTH-1:0] oreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvld1_q  <= 1'b0;
      rvalid_q <= 1'b0;
      oreg_q   <= '0;
    end else begin
      rvld1_q  <= rd_en;
      rvalid_q <= rvld1_q;
      if (rvld1_q) oreg_q <= bank_rdata[rsel_q];
    end
  end

  assign rdat   = oreg_q;
  assign rvalid = rvalid_q;
`else
  // rsel_q remembers which bank served the last read, so a read issued with rd_rel still returns its data.
  assign rdat = bank_rdata[rsel_q];
`endif

endmodule

// File: tb/tb_in_pp_ram.sv
// Self-checking bench for in_pp_ram: directed scenarios then random traffic against a behavioural model.
module tb_in_pp_ram;

  localparam int DW = 160;
  localparam int WORDS = 64;
  localparam int NBANK = 2;
  localparam int AW = 6;

  logic          clk, rst_n, wen, wlast, rd_acq, ren, rd_rel;
  logic [DW-1:0] wdat, rdat;
  logic [AW-1:0] raddr;
  logic [AW:0]   rd_cnt;
  logic          w_ready, w_ovf, r_avail;
`ifdef IN_PP_RAM_OREG_EN
  logic          rvalid;
`endif

  in_pp_ram #(.DWIDTH(DW), .WORDS(WORDS), .NBANK(NBANK)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wen     (wen),
    .wlast   (wlast),
    .wdat    (wdat),
    .w_ready (w_ready),
    .w_ovf   (w_ovf),
    .r_avail (r_avail),
    .rd_acq  (rd_acq),
    .ren     (ren),
    .raddr   (raddr),
    .rdat    (rdat),
    .rd_cnt  (rd_cnt),
`ifdef IN_PP_RAM_OREG_EN
    .rvalid  (rvalid),
`endif
    .rd_rel  (rd_rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: 0=empty 1=filling 2=full 3=reading
  int            ms    [NBANK];
  int            mcnt  [NBANK];
  int            mwb, mrb, mwcnt;
  bit            movf;
  logic [DW-1:0] mmem  [NBANK][WORDS];
  bit            mknown[NBANK][WORDS];
  logic [DW-1:0] mrdat;
  bit            mrdat_k;
  bit            mp_v, mp_k, mrvalid;
  logic [DW-1:0] mp_d;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic compare_all();
    chk("w_ready", DW'(w_ready), DW'(ms[mwb] <= 1));
    chk("r_avail", DW'(r_avail), DW'(ms[mrb] == 2));
    chk("rd_cnt",  DW'(rd_cnt),  (ms[mrb] >= 2) ? DW'(mcnt[mrb]) : '0);
    chk("w_ovf",   DW'(w_ovf),   DW'(movf));
    if (mrdat_k) chk("rdat", rdat, mrdat);
`ifdef IN_PP_RAM_OREG_EN
    chk("rvalid", DW'(rvalid), DW'(mrvalid));
`endif
  endtask

  task automatic model_reset();
    for (int b = 0; b < NBANK; b++) begin
      ms[b] = 0;
      mcnt[b] = 0;
    end
    mwb = 0; mrb = 0; mwcnt = 0; movf = 0;
    mrdat = '0; mrdat_k = 1; mp_v = 0; mp_k = 0; mp_d = '0; mrvalid = 0;
  endtask

  task automatic step(input bit i_wen, input bit i_wlast, input logic [DW-1:0] i_wdat,
                      input bit i_acq, input bit i_ren, input int i_raddr, input bit i_rel);
    bit wrdy, rok, rk;
    int rbst;
    logic [DW-1:0] rv;
    wen = i_wen; wlast = i_wlast; wdat = i_wdat;
    rd_acq = i_acq; ren = i_ren; raddr = AW'(i_raddr); rd_rel = i_rel;
    @(posedge clk);
    wrdy = (ms[mwb] <= 1);
    rbst = ms[mrb];
    rok  = i_ren && rbst == 3;
    rv   = mmem[mrb][i_raddr];
    rk   = mknown[mrb][i_raddr];
    if (i_wen && wrdy) begin
      mmem[mwb][mwcnt] = i_wdat;
      mknown[mwb][mwcnt] = 1;
      if (mwcnt == WORDS - 1 || i_wlast) begin
        ms[mwb] = 2;
        mcnt[mwb] = mwcnt + 1;
        mwb = (mwb + 1) % NBANK;
        mwcnt = 0;
      end else begin
        ms[mwb] = 1;
        mwcnt++;
      end
    end else if (i_wen) begin
      movf = 1;
    end
    if (i_rel && rbst == 3) begin
      ms[mrb] = 0;
      mrb = (mrb + 1) % NBANK;
    end else if (i_acq && rbst == 2) begin
      ms[mrb] = 3;
    end
`ifdef IN_PP_RAM_OREG_EN
    if (mp_v) begin
      mrdat = mp_d;
      mrdat_k = mp_k;
    end
    mrvalid = mp_v;
    mp_v = rok;
    if (rok) begin
      mp_d = rv;
      mp_k = rk;
    end
`else
    if (rok) begin
      mrdat = rv;
      mrdat_k = rk;
    end
`endif
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit last);
    step(1, last, d, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wen = 0; wlast = 0; rd_acq = 0; ren = 0; rd_rel = 0; wdat = '0; raddr = '0;
    #2;
    model_reset();
    chk("rst_w_ready", DW'(w_ready), DW'(1));
    chk("rst_r_avail", DW'(r_avail), '0);
    chk("rst_rd_cnt",  DW'(rd_cnt),  '0);
    chk("rst_rdat",    rdat,         '0);
    chk("rst_w_ovf",   DW'(w_ovf),   '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    for (int b = 0; b < NBANK; b++)
      for (int a = 0; a < WORDS; a++) begin
        mmem[b][a] = '0;
        mknown[b][a] = 0;
      end
    model_reset();
    rst_n = 1'b0;
    wen = 0; wlast = 0; rd_acq = 0; ren = 0; rd_rel = 0; wdat = '0; raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: full bank of 0..63
    for (int i = 0; i < WORDS; i++) wr(DW'(i), 0);
    chk("t1_r_avail", DW'(r_avail), DW'(1));
    chk("t1_rd_cnt", DW'(rd_cnt), DW'(64));
    chk("t1_w_ready", DW'(w_ready), DW'(1));

    // 2: claim, read address 5, release
    step(0, 0, '0, 1, 0, 0, 0);
    step(0, 0, '0, 0, 1, 5, 0);
`ifdef IN_PP_RAM_OREG_EN
    idle();
`endif
    chk("t2_rdat", rdat, DW'(5));
    step(0, 0, '0, 0, 0, 0, 1);
    chk("t2_r_avail", DW'(r_avail), '0);

    // 3: short tile closed by wlast, next word starts the other bank
    for (int i = 0; i < 10; i++) wr(DW'(100 + i), i == 9);
    chk("t3_rd_cnt", DW'(rd_cnt), DW'(10));
    wr(DW'('hABC), 0);

    // 4: both banks full, overflow, then release frees a bank
    for (int i = 1; i < WORDS; i++) wr(DW'(200 + i), 0);
    chk("t4_w_ready", DW'(w_ready), '0);
    wr(DW'('hDEAD), 0);
    chk("t4_w_ovf", DW'(w_ovf), DW'(1));
    step(0, 0, '0, 1, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 1);
    chk("t4_w_ready_after", DW'(w_ready), DW'(1));

    // 5: bank close and release of the other bank in one cycle
    step(0, 0, '0, 1, 0, 0, 0);
    step(0, 0, '0, 0, 1, 0, 0);
`ifdef IN_PP_RAM_OREG_EN
    idle();
`endif
    chk("t5_rdat0", rdat, DW'('hABC));
    for (int i = 0; i < 9; i++) wr(DW'(300 + i), 0);
    step(1, 1, DW'(309), 0, 0, 0, 1);
    chk("t5_r_avail", DW'(r_avail), DW'(1));
    chk("t5_rd_cnt", DW'(rd_cnt), DW'(10));
    chk("t5_w_ready", DW'(w_ready), DW'(1));

    // 6: reset mid-fill then refill from address 0
    step(0, 0, '0, 1, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++) wr(DW'(400 + i), 0);
    do_reset();
    for (int i = 0; i < 3; i++) wr(DW'(500 + i), i == 2);
    chk("t6_rd_cnt", DW'(rd_cnt), DW'(3));
    step(0, 0, '0, 1, 0, 0, 0);
    step(0, 0, '0, 0, 1, 0, 0);
    idle();
    chk("t6_rdat", rdat, DW'(500));

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 6, rnd_word(),
             $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 50,
             int'($urandom_range(0, WORDS - 1)), $urandom_range(0, 99) < 8);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
